// File: rtl/wisc_alu.sv
// WISC-15 execute-stage ALU: combinational 16-bit result plus a clocked
// zero/negative/overflow flag register consumed by branches.
module wisc_alu (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [15:0] A,
    input  logic [15:0] B,
    input  logic [3:0]  Alu_Ctrl,
    input  logic        flag_en,
    output logic [15:0] Result,
    output logic        z,
    output logic        n,
    output logic        v
);

    localparam logic [3:0] OP_ADD    = 4'b0000;
    localparam logic [3:0] OP_SUB    = 4'b0001;
    localparam logic [3:0] OP_PADDSB = 4'b0010;
    localparam logic [3:0] OP_LHB    = 4'b0011;
    localparam logic [3:0] OP_NAND   = 4'b0100;
    localparam logic [3:0] OP_SLL    = 4'b0101;
    localparam logic [3:0] OP_SRL    = 4'b0110;
    localparam logic [3:0] OP_SRA    = 4'b0111;
    localparam logic [3:0] OP_XOR    = 4'b1000;
    localparam logic [3:0] OP_PASSB  = 4'b1001;

    logic        is_sub;
    logic [15:0] b_op;
    logic [15:0] as_sum;
    logic        as_ovf;
    logic [15:0] as_sat;

    logic [7:0]  hi_sum;
    logic [7:0]  lo_sum;
    logic        hi_ovf;
    logic        lo_ovf;
    logic [7:0]  hi_sat;
    logic [7:0]  lo_sat;

    logic [3:0]  shamt;
    logic [15:0] sll_res;
    logic [15:0] srl_res;
    logic [15:0] sra_res;

    logic        upd_all;
    logic        upd_z;
    logic        res_zero;

    // SUB reuses the adder as A + ~B + 1; overflow is judged on the inverted operand.
    assign is_sub = (Alu_Ctrl == OP_SUB);
    assign b_op   = is_sub ? ~B : B;
    assign as_sum = A + b_op + {15'd0, is_sub};
    assign as_ovf = (A[15] == b_op[15]) && (as_sum[15] != A[15]);
    assign as_sat = as_ovf ? (A[15] ? 16'h8000 : 16'h7FFF) : as_sum;

    assign hi_sum = A[15:8] + B[15:8];
    assign lo_sum = A[7:0] + B[7:0];
    assign hi_ovf = (A[15] == B[15]) && (hi_sum[7] != A[15]);
    assign lo_ovf = (A[7] == B[7]) && (lo_sum[7] != A[7]);
    assign hi_sat = hi_ovf ? (A[15] ? 8'h80 : 8'h7F) : hi_sum;
    assign lo_sat = lo_ovf ? (A[7] ? 8'h80 : 8'h7F) : lo_sum;

    assign shamt   = B[3:0];
    assign sll_res = A << shamt;
    assign srl_res = A >> shamt;
    assign sra_res = 16'($signed(A) >>> shamt);

    always_comb begin
        Result = 16'h0000;
        case (Alu_Ctrl)
            OP_ADD, OP_SUB: Result = as_sat;
            OP_PADDSB:      Result = {hi_sat, lo_sat};
            OP_LHB:         Result = {B[7:0], A[7:0]};
            OP_NAND:        Result = ~(A & B);
            OP_SLL:         Result = sll_res;
            OP_SRL:         Result = srl_res;
            OP_SRA:         Result = sra_res;
            OP_XOR:         Result = A ^ B;
            OP_PASSB:       Result = B;
            default:        Result = 16'h0000;
        endcase
    end

    assign res_zero = (Result == 16'h0000);
    assign upd_all  = flag_en && ((Alu_Ctrl == OP_ADD) || (Alu_Ctrl == OP_SUB));
    assign upd_z    = flag_en && ((Alu_Ctrl == OP_NAND) || (Alu_Ctrl == OP_XOR) ||
                                  (Alu_Ctrl == OP_SLL)  || (Alu_Ctrl == OP_SRL) ||
                                  (Alu_Ctrl == OP_SRA));

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            z <= 1'b0;
            n <= 1'b0;
            v <= 1'b0;
        end else if (upd_all) begin
            z <= res_zero;
            n <= Result[15];
            v <= as_ovf;
        end else if (upd_z) begin
            z <= res_zero;
        end
    end

endmodule

// File: tb/tb_wisc_alu.sv
// Bench for wisc_alu: directed vector table, reset sequence, sweeps and
// randomized operations against an arithmetic reference model.
module tb_wisc_alu;

    logic        clk;
    logic        rst_n;
    logic [15:0] a;
    logic [15:0] b;
    logic [3:0]  ctrl;
    logic        fe;
    logic [15:0] result;
    logic        z;
    logic        n;
    logic        v;

    int n_vec;
    int n_err;

    logic mz, mn, mv;

    typedef struct packed {
        logic [3:0]  ctrl;
        logic [15:0] a;
        logic [15:0] b;
        logic        fe;
        logic [15:0] res;
        logic [2:0]  znv;
    } vec_t;

    vec_t tbl [20];

    wisc_alu dut (
        .clk      (clk),
        .rst_n    (rst_n),
        .A        (a),
        .B        (b),
        .Alu_Ctrl (ctrl),
        .flag_en  (fe),
        .Result   (result),
        .z        (z),
        .n        (n),
        .v        (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [15:0] got, input logic [15:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h (ctrl=%h a=%h b=%h)", name, got, exp, ctrl, a, b);
        end
    endtask

    function automatic int clamp(input int x, input int lo, input int hi);
        if (x > hi) return hi;
        if (x < lo) return lo;
        return x;
    endfunction

    // Reference result from plain integer arithmetic; ovf reports ADD/SUB saturation.
    function automatic logic [15:0] ref_res(input logic [3:0] c, input logic [15:0] ia,
                                            input logic [15:0] ib, output bit ovf);
        int sa, sb, ua, x, hi, lo, d, q;
        logic [15:0] r;
        sa = $signed(ia);
        sb = $signed(ib);
        ua = ia;
        d  = 1 << ib[3:0];
        ovf = 1'b0;
        r = 16'h0000;
        case (c)
            4'd0: begin x = sa + sb; ovf = (x > 32767) || (x < -32768); x = clamp(x, -32768, 32767); r = x[15:0]; end
            4'd1: begin x = sa - sb; ovf = (x > 32767) || (x < -32768); x = clamp(x, -32768, 32767); r = x[15:0]; end
            4'd2: begin
                hi = clamp(int'($signed(ia[15:8])) + int'($signed(ib[15:8])), -128, 127);
                lo = clamp(int'($signed(ia[7:0])) + int'($signed(ib[7:0])), -128, 127);
                r = {hi[7:0], lo[7:0]};
            end
            4'd3: r = {ib[7:0], ia[7:0]};
            4'd4: r = ~(ia & ib);
            4'd5: begin x = ua * d; r = x[15:0]; end
            4'd6: begin x = ua / d; r = x[15:0]; end
            4'd7: begin
                q = sa / d;
                if ((sa % d != 0) && (sa < 0)) q = q - 1;
                r = q[15:0];
            end
            4'd8: r = ia ^ ib;
            4'd9: r = ib;
            default: r = 16'h0000;
        endcase
        return r;
    endfunction

    task automatic model_edge();
        bit ovf;
        logic [15:0] r;
        r = ref_res(ctrl, a, b, ovf);
        if (fe) begin
            if (ctrl == 4'd0 || ctrl == 4'd1) begin
                mz = (r == 16'h0); mn = r[15]; mv = ovf;
            end else if (ctrl inside {4'd4, 4'd5, 4'd6, 4'd7, 4'd8}) begin
                mz = (r == 16'h0);
            end
        end
    endtask

    task automatic drive(input logic [3:0] c, input logic [15:0] ia, input logic [15:0] ib, input logic f);
        @(negedge clk);
        ctrl = c; a = ia; b = ib; fe = f;
        #1;
    endtask

    initial begin
        bit ovf;
        logic [15:0] exp;
        n_vec = 0; n_err = 0;
        rst_n = 1'b0; a = '0; b = '0; ctrl = '0; fe = 1'b0;

        tbl[0]  = '{4'h0, 16'h7FFF, 16'h0001, 1'b1, 16'h7FFF, 3'b001};
        tbl[1]  = '{4'h0, 16'h8000, 16'hFFFF, 1'b1, 16'h8000, 3'b011};
        tbl[2]  = '{4'h1, 16'h0005, 16'h0005, 1'b1, 16'h0000, 3'b100};
        tbl[3]  = '{4'h8, 16'h0001, 16'h0000, 1'b1, 16'h0001, 3'b000};
        tbl[4]  = '{4'h7, 16'h8000, 16'h0004, 1'b0, 16'hF800, 3'b000};
        tbl[5]  = '{4'h6, 16'h8000, 16'h0004, 1'b0, 16'h0800, 3'b000};
        tbl[6]  = '{4'h5, 16'h0001, 16'h000F, 1'b1, 16'h8000, 3'b000};
        tbl[7]  = '{4'h2, 16'h7F80, 16'h01FF, 1'b1, 16'h7F80, 3'b000};
        tbl[8]  = '{4'h4, 16'h00FF, 16'h0F0F, 1'b0, 16'hFFF0, 3'b000};
        tbl[9]  = '{4'h4, 16'h0000, 16'h0000, 1'b1, 16'hFFFF, 3'b000};
        tbl[10] = '{4'h8, 16'h1234, 16'h00FF, 1'b0, 16'h12CB, 3'b000};
        tbl[11] = '{4'h3, 16'h1234, 16'hABCD, 1'b1, 16'hCD34, 3'b000};
        tbl[12] = '{4'h9, 16'h0000, 16'hBEEF, 1'b1, 16'hBEEF, 3'b000};
        tbl[13] = '{4'hA, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 3'b000};
        tbl[14] = '{4'h1, 16'h8000, 16'h0001, 1'b1, 16'h8000, 3'b011};
        tbl[15] = '{4'h0, 16'h4000, 16'h4000, 1'b1, 16'h7FFF, 3'b001};
        tbl[16] = '{4'h7, 16'h8001, 16'hFFF0, 1'b1, 16'h8001, 3'b001};
        tbl[17] = '{4'h4, 16'hFFFF, 16'hFFFF, 1'b1, 16'h0000, 3'b101};
        tbl[18] = '{4'h9, 16'h0000, 16'h0000, 1'b1, 16'h0000, 3'b101};
        tbl[19] = '{4'h1, 16'h0000, 16'h8000, 1'b1, 16'h7FFF, 3'b001};

        #2;
        chk("reset_flags", {13'd0, z, n, v}, 16'h0000);
        @(negedge clk);
        rst_n = 1'b1;

        for (int i = 0; i < 20; i++) begin
            drive(tbl[i].ctrl, tbl[i].a, tbl[i].b, tbl[i].fe);
            chk($sformatf("tbl%0d_result", i), result, tbl[i].res);
            @(posedge clk); #1;
            chk($sformatf("tbl%0d_flags", i), {13'd0, z, n, v}, {13'd0, tbl[i].znv});
        end

        // Reset asserted between edges with all three flags set.
        drive(4'h0, 16'h8000, 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        drive(4'h4, 16'hFFFF, 16'hFFFF, 1'b1);
        @(posedge clk); #1;
        chk("pre_reset_flags", {13'd0, z, n, v}, 16'h0007);
        #2 rst_n = 1'b0;
        #1 chk("async_reset_flags", {13'd0, z, n, v}, 16'h0000);
        drive(4'h0, 16'h7FFF, 16'h0001, 1'b1);
        chk("reset_result_unaffected", result, 16'h7FFF);
        for (int i = 0; i < 2; i++) begin
            @(posedge clk); #1;
            chk("held_in_reset", {13'd0, z, n, v}, 16'h0000);
        end
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        chk("first_update_after_reset", {13'd0, z, n, v}, 16'h0001);
        mz = 1'b0; mn = 1'b0; mv = 1'b1;

        // Subsampled NAND/XOR grids, combinational only.
        fe = 1'b0;
        for (int op = 0; op < 2; op++) begin
            ctrl = (op == 0) ? 4'h4 : 4'h8;
            for (int ia = 0; ia <= 16'h7FFF; ia += 31) begin
                for (int ib = 0; ib <= 16'h7FFF; ib += 73 * 16) begin
                    a = ia[15:0]; b = ib[15:0];
                    #1;
                    exp = (op == 0) ? ~(a & b) : (a ^ b);
                    chk(op == 0 ? "nand_sweep" : "xor_sweep", result, exp);
                end
            end
        end

        // Random operations with flag tracking.
        for (int i = 0; i < 3000; i++) begin
            logic [15:0] ra, rb;
            ra = $urandom();
            rb = $urandom();
            if ($urandom_range(0, 7) == 0) ra = ($urandom_range(0, 1) != 0) ? 16'h7FFF : 16'h8000;
            if ($urandom_range(0, 7) == 0) rb = rb & 16'h000F;
            if ($urandom_range(0, 9) == 0) rb = ra;
            drive(4'($urandom_range(0, 15)), ra, rb, 1'($urandom_range(0, 1)));
            chk("rand_result", result, ref_res(ctrl, a, b, ovf));
            model_edge();
            @(posedge clk); #1;
            chk("rand_flags", {13'd0, z, n, v}, {13'd0, mz, mn, mv});
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
